dmem_initiator: RTL and testbench
=================================

// Module: dmem_initiator
// PURPOSE
//  Initiator (master) side of the data-memory port. Takes one load/store request
//  at a time from the MEM stage. Drives memwrite/dataadr/writedata/byteen toward
//  dcache, waits for readdata or dataack, and returns aligned, extended load data.
//  Stalls the pipeline while busy. Big-endian byte lanes throughout.
// PARAMETERS
//  READ_WAIT  1    cycles from address drive to readdata capture (1..15)
//  TIMEOUT    15   max cycles in WRITE without dataack before error (1..255)
// PORTS
//  ph1         in   1   single clock, all state updates on posedge ph1
//  reset_b     in   1   asynchronous, active-low reset
//  req_valid   in   1   MEM stage presents a request
//  req_ready   out  1   block can accept request this cycle (state IDLE)
//  req_write   in   1   1=store, 0=load
//  req_size    in   2   00=byte 01=half 10=word 11=illegal
//  req_signed  in   1   sign-extend load result (byte/half only)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified
//  resp_valid  out  1   one-cycle pulse: request finished
//  resp_rdata  out  32  load result, valid with resp_valid (0 for stores)
//  resp_err    out  2   with resp_valid: 00 ok, 01 misaligned/illegal, 10 timeout
//  stall       out  1   = req_valid & ~req_ready, or busy (state != IDLE)
//  memwrite    out  1   write enable to dcache
//  dataadr     out  32  word-aligned address ({addr[31:2],2'b00})
//  writedata   out  32  lane-replicated store data
//  byteen      out  4   byte lane enables; [3]=bits 31:24 = byte offset 0
//  readdata    in   32  dcache read word
//  dataack     in   1   dcache write acknowledge (delayed, level)
// BEHAVIOUR
//  Reset: state IDLE; memwrite=0, byteen=0, dataadr=0, writedata=0,
//   resp_valid=0, resp_rdata=0, resp_err=0, counters=0. Reset mid-op aborts
//   the op with no response.
//  States: IDLE, READ, WRITE, DRAIN.
//  IDLE: req_ready=1. On req_valid, latch all req_* fields.
//   Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11:
//    no bus activity; resp_valid next cycle, err=01; stay IDLE.
//   Load -> READ, counter=0. Store -> WRITE, counter=0.
//  Lanes: byte off k -> byteen bit (3-k); half off 0 -> 1100, off 2 -> 0011;
//   word -> 1111. writedata = byte x4, half x2, or word.
//  READ: dataadr driven, memwrite=0, byteen=0. After READ_WAIT cycles, capture
//   readdata. Select lane by offset/size, zero- or sign-extend to 32b.
//   Pulse resp_valid with err=00; go to IDLE.
//  WRITE: memwrite=1; dataadr/writedata/byteen held constant (repeat writes are
//   idempotent). On the first cycle dataack=1: memwrite=0 next cycle, resp_valid
//   pulse err=00, go to DRAIN. If counter reaches TIMEOUT first: same, err=10.
//  DRAIN: memwrite=0; wait until dataack=0 (stale delayed acks), then IDLE.
//   No new request is accepted in DRAIN.
//  dataack seen in IDLE or READ is ignored.
//  Counters saturate; never wrap.
//  req_valid held during resp_valid is treated as a new request only in IDLE
//   (caller drops req_valid on resp_valid).
//  Throughput: load = READ_WAIT+1 cycles; store = ack latency + drain time.
// TESTING
//  1 Word store 0xDEADBEEF @0x40, ack 3 cycles later -> byteen=1111,
//    dataadr=0x40; memwrite high until ack; resp_valid err=00; DRAIN until ack=0.
//  2 Byte store 0xAB @0x43, then signed byte load @0x43 -> byteen=0001,
//    writedata=0xABABABAB; load resp_rdata=0xFFFFFFAB; unsigned gives 0x000000AB.
//  3 Half load @0x42, word=0x1234ABCD, signed -> resp_rdata=0xFFFFABCD;
//    same access @0x40 -> 0x00001234.
//  4 Word load @0x41 and size=11 -> no memwrite, dataadr unchanged,
//    resp_err=01 next cycle.
//  5 Store with dataack tied 0, TIMEOUT=15 -> resp_err=10 after 15 WRITE cycles.
//    Then raise/drop ack: IDLE only after ack=0.
//  6 reset_b low during WRITE -> memwrite=0 immediately (async), no resp_valid,
//    req_ready=1 after release.

Source files
------------

// File: rtl/dmem_initiator_if.sv
// Data-memory bus between the initiator and dcache: write strobe, word address,
// lane-replicated write data, big-endian byte enables, read word and write ack.
interface dmem_initiator_if;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [3:0]  byteen;
   logic [31:0] readdata;
   logic        dataack;

   modport master (
      output memwrite, dataadr, writedata, byteen,
      input  readdata, dataack
   );

   modport slave (
      input  memwrite, dataadr, writedata, byteen,
      output readdata, dataack
   );
endinterface

// File: rtl/dmem_initiator.sv
// Data-memory initiator: one load/store at a time from the MEM stage, drives the
// dcache bus, returns aligned and extended load data. Big-endian byte lanes.
module dmem_initiator #(
   parameter int unsigned READ_WAIT = 1,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic        ph1,
   input  logic        reset_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic        stall,
   dmem_initiator_if.master dbus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DRAIN} state_e;
   typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_ALIGN = 2'b01, ERR_TIMEOUT = 2'b10} err_e;

   localparam logic [7:0] READ_LAST  = 8'(READ_WAIT - 1);
   localparam logic [7:0] WRITE_LAST = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic        signed_q, signed_d;
   logic        memwrite_q, memwrite_d;
   logic [31:0] dataadr_q, dataadr_d;
   logic [31:0] writedata_q, writedata_d;
   logic [3:0]  byteen_q, byteen_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [1:0]  resp_err_q, resp_err_d;
   logic        req_illegal;

   function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] en;
      unique case (size)
         2'b00:   en = 4'b1000 >> off;
         2'b01:   en = off[1] ? 4'b0011 : 4'b1100;
         default: en = 4'b1111;
      endcase
      return en;
   endfunction

   function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] rep;
      unique case (size)
         2'b00:   rep = {4{wdata[7:0]}};
         2'b01:   rep = {2{wdata[15:0]}};
         default: rep = wdata;
      endcase
      return rep;
   endfunction

   // Offset 0 is the most significant byte of the word.
   function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] off,
                                                input logic sext, input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      unique case (off)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      h = off[1] ? word[15:0] : word[31:16];
      unique case (size)
         2'b00:   r = {{24{sext & b[7]}}, b};
         2'b01:   r = {{16{sext & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign req_illegal = (req_size == 2'b11) ||
                        (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   always_comb begin
      // NOTE: every signal gets its hold/default value first so no path leaves one unassigned (no latches).
      state_d      = state_q;
      cnt_d        = cnt_q;
      size_d       = size_q;
      off_d        = off_q;
      signed_d     = signed_q;
      memwrite_d   = memwrite_q;
      dataadr_d    = dataadr_q;
      writedata_d  = writedata_q;
      byteen_d     = byteen_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               size_d   = req_size;
               off_d    = req_addr[1:0];
               signed_d = req_signed;
               if (req_illegal) begin
                  resp_valid_d = 1'b1;
                  resp_rdata_d = '0;
                  resp_err_d   = ERR_ALIGN;
               end else begin
                  cnt_d     = '0;
                  dataadr_d = {req_addr[31:2], 2'b00};
                  if (req_write) begin
                     state_d     = WRITE;
                     memwrite_d  = 1'b1;
                     writedata_d = lane_rep(req_size, req_wdata);
                     byteen_d    = lane_en(req_size, req_addr[1:0]);
                  end else begin
                     state_d    = READ;
                     memwrite_d = 1'b0;
                     byteen_d   = '0;
                  end
               end
            end
         end
         READ: begin
            if (cnt_q == READ_LAST) begin
               state_d      = IDLE;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_extract(size_q, off_q, signed_q, dbus.readdata);
               resp_err_d   = ERR_OK;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         WRITE: begin
            // An ack on the last counted cycle still wins over the timeout.
            if (dbus.dataack || cnt_q == WRITE_LAST) begin
               state_d      = DRAIN;
               memwrite_d   = 1'b0;
               byteen_d     = '0;
               resp_valid_d = 1'b1;
               resp_rdata_d = '0;
               resp_err_d   = dbus.dataack ? ERR_OK : ERR_TIMEOUT;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         DRAIN: begin
            memwrite_d = 1'b0;
            if (!dbus.dataack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ph1 or negedge reset_b) begin
      if (!reset_b) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         size_q       <= '0;
         off_q        <= '0;
         signed_q     <= 1'b0;
         memwrite_q   <= 1'b0;
         dataadr_q    <= '0;
         writedata_q  <= '0;
         byteen_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         size_q       <= size_d;
         off_q        <= off_d;
         signed_q     <= signed_d;
         memwrite_q   <= memwrite_d;
         dataadr_q    <= dataadr_d;
         writedata_q  <= writedata_d;
         byteen_q     <= byteen_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready      = (state_q == IDLE);
   assign stall          = (req_valid & ~req_ready) | (state_q != IDLE);
   assign resp_valid     = resp_valid_q;
   assign resp_rdata     = resp_rdata_q;
   assign resp_err       = resp_err_q;
   assign dbus.memwrite  = memwrite_q;
   assign dbus.dataadr   = dataadr_q;
   assign dbus.writedata = writedata_q;
   assign dbus.byteen    = byteen_q;

endmodule

// File: tb/tb_dmem_initiator.sv
// Directed bench for dmem_initiator: stores, loads with lane select/extension,
// illegal requests, write timeout with drain, and async reset mid-write.
module tb_dmem_initiator;

   logic        ph1;
   logic        reset_b;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        stall;

   int checks = 0;
   int errors = 0;
   int n;

   dmem_initiator_if bus ();

   dmem_initiator #(.READ_WAIT(1), .TIMEOUT(15)) dut (
      .ph1        (ph1),
      .reset_b    (reset_b),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .stall      (stall),
      .dbus       (bus.master)
   );

   initial ph1 = 1'b0;
   always #5 ph1 = ~ph1;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge ph1);
   endtask

   // Present one request for a single clock edge, then withdraw it.
   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = d;
      tick();
      req_valid  = 1'b0;
   endtask

   task automatic wait_resp(output int cnt, input int limit);
      cnt = 0;
      while (resp_valid !== 1'b1 && cnt < limit) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      reset_b      = 1'b0;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_size     = 2'b00;
      req_signed   = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      bus.readdata = '0;
      bus.dataack  = 1'b0;

      // Reset state
      tick();
      check("rst req_ready",  32'(req_ready), 32'd1);
      check("rst stall",      32'(stall), 32'd0);
      check("rst memwrite",   32'(bus.memwrite), 32'd0);
      check("rst byteen",     32'(bus.byteen), 32'd0);
      check("rst dataadr",    bus.dataadr, 32'd0);
      check("rst writedata",  bus.writedata, 32'd0);
      check("rst resp_valid", 32'(resp_valid), 32'd0);
      check("rst resp_rdata", resp_rdata, 32'd0);
      check("rst resp_err",   32'(resp_err), 32'd0);
      reset_b = 1'b1;
      tick();

      // 1: word store, ack after three cycles, then drain
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF);
      check("t1 memwrite",   32'(bus.memwrite), 32'd1);
      check("t1 byteen",     32'(bus.byteen), 32'hF);
      check("t1 dataadr",    bus.dataadr, 32'h40);
      check("t1 writedata",  bus.writedata, 32'hDEAD_BEEF);
      check("t1 req_ready",  32'(req_ready), 32'd0);
      check("t1 stall",      32'(stall), 32'd1);
      check("t1 resp_valid", 32'(resp_valid), 32'd0);
      tick();
      tick();
      check("t1 memwrite held", 32'(bus.memwrite), 32'd1);
      check("t1 byteen held",   32'(bus.byteen), 32'hF);
      bus.dataack = 1'b1;
      tick();
      check("t1 resp_valid", 32'(resp_valid), 32'd1);
      check("t1 resp_err",   32'(resp_err), 32'd0);
      check("t1 resp_rdata", resp_rdata, 32'd0);
      check("t1 memwrite off", 32'(bus.memwrite), 32'd0);
      tick();
      check("t1 drain stall",  32'(stall), 32'd1);
      check("t1 drain ready",  32'(req_ready), 32'd0);
      check("t1 drain pulse",  32'(resp_valid), 32'd0);
      bus.dataack = 1'b0;
      tick();
      check("t1 idle ready", 32'(req_ready), 32'd1);
      check("t1 idle stall", 32'(stall), 32'd0);

      // 2: byte store @0x43, then byte loads from the same lane
      issue(1'b1, 2'b00, 1'b0, 32'h0000_0043, 32'h0000_00AB);
      check("t2 byteen",    32'(bus.byteen), 32'h1);
      check("t2 writedata", bus.writedata, 32'hABAB_ABAB);
      check("t2 dataadr",   bus.dataadr, 32'h40);
      bus.dataack = 1'b1;
      tick();
      check("t2 st resp_valid", 32'(resp_valid), 32'd1);
      check("t2 st resp_err",   32'(resp_err), 32'd0);
      bus.dataack = 1'b0;
      tick();
      check("t2 st idle", 32'(req_ready), 32'd1);

      bus.readdata = 32'h0000_00AB;
      bus.dataack  = 1'b1;   // stray ack in IDLE/READ must be ignored
      issue(1'b0, 2'b00, 1'b1, 32'h0000_0043, 32'h0);
      check("t2 ld memwrite", 32'(bus.memwrite), 32'd0);
      check("t2 ld byteen",   32'(bus.byteen), 32'd0);
      check("t2 ld stall",    32'(stall), 32'd1);
      wait_resp(n, 10);
      check("t2 ld latency",  32'(n), 32'd1);
      check("t2 ld signed",   resp_rdata, 32'hFFFF_FFAB);
      check("t2 ld err",      32'(resp_err), 32'd0);
      check("t2 ld idle",     32'(req_ready), 32'd1);
      bus.dataack = 1'b0;
      issue(1'b0, 2'b00, 1'b0, 32'h0000_0043, 32'h0);
      wait_resp(n, 10);
      check("t2 ld unsigned", resp_rdata, 32'h0000_00AB);

      // 3: half loads from both halves, plus a word load
      bus.readdata = 32'h1234_ABCD;
      issue(1'b0, 2'b01, 1'b1, 32'h0000_0042, 32'h0);
      wait_resp(n, 10);
      check("t3 half lo signed", resp_rdata, 32'hFFFF_ABCD);
      issue(1'b0, 2'b01, 1'b1, 32'h0000_0040, 32'h0);
      wait_resp(n, 10);
      check("t3 half hi signed", resp_rdata, 32'h0000_1234);
      issue(1'b0, 2'b01, 1'b0, 32'h0000_0042, 32'h0);
      wait_resp(n, 10);
      check("t3 half lo unsigned", resp_rdata, 32'h0000_ABCD);
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0);
      check("t3 word dataadr", bus.dataadr, 32'h44);
      wait_resp(n, 10);
      check("t3 word", resp_rdata, 32'h1234_ABCD);

      // 4: misaligned and illegal-size requests
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0041, 32'h0);
      check("t4 mis resp_valid", 32'(resp_valid), 32'd1);
      check("t4 mis resp_err",   32'(resp_err), 32'd1);
      check("t4 mis memwrite",   32'(bus.memwrite), 32'd0);
      check("t4 mis dataadr",    bus.dataadr, 32'h44);
      check("t4 mis ready",      32'(req_ready), 32'd1);
      tick();
      check("t4 mis pulse end",  32'(resp_valid), 32'd0);
      issue(1'b0, 2'b11, 1'b0, 32'h0000_0048, 32'h0);
      check("t4 ill resp_valid", 32'(resp_valid), 32'd1);
      check("t4 ill resp_err",   32'(resp_err), 32'd1);
      check("t4 ill dataadr",    bus.dataadr, 32'h44);
      issue(1'b1, 2'b01, 1'b0, 32'h0000_0045, 32'h5555);
      check("t4 half st err",      32'(resp_err), 32'd1);
      check("t4 half st memwrite", 32'(bus.memwrite), 32'd0);
      check("t4 half st byteen",   32'(bus.byteen), 32'd0);

      // 5: store timeout, then a stale ack holds DRAIN and blocks requests
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0080, 32'h1122_3344);
      wait_resp(n, 40);
      check("t5 timeout cycles", 32'(n), 32'd15);
      check("t5 timeout err",    32'(resp_err), 32'd2);
      check("t5 memwrite off",   32'(bus.memwrite), 32'd0);
      bus.dataack = 1'b1;
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_size    = 2'b10;
      req_addr    = 32'h0000_0040;
      tick();
      check("t5 drain ready",  32'(req_ready), 32'd0);
      check("t5 drain stall",  32'(stall), 32'd1);
      check("t5 drain pulse",  32'(resp_valid), 32'd0);
      tick();
      check("t5 drain hold",   32'(req_ready), 32'd0);
      req_valid   = 1'b0;
      bus.dataack = 1'b0;
      tick();
      check("t5 idle ready",   32'(req_ready), 32'd1);
      check("t5 idle stall",   32'(stall), 32'd0);
      check("t5 no accept",    32'(resp_valid), 32'd0);

      // 6: asynchronous reset in the middle of a write
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hCAFE_F00D);
      check("t6 memwrite", 32'(bus.memwrite), 32'd1);
      #2 reset_b = 1'b0;
      #1;
      check("t6 async memwrite", 32'(bus.memwrite), 32'd0);
      check("t6 async byteen",   32'(bus.byteen), 32'd0);
      check("t6 async dataadr",  bus.dataadr, 32'd0);
      tick();
      reset_b = 1'b1;
      tick();
      check("t6 ready",     32'(req_ready), 32'd1);
      check("t6 no resp",   32'(resp_valid), 32'd0);
      tick();
      check("t6 still no resp", 32'(resp_valid), 32'd0);
      check("t6 memwrite idle", 32'(bus.memwrite), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
